// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer for the playfield store: scans bottom-up, drops full rows,
// zero-fills the top, and keeps a saturating 3-digit BCD score plus a sticky game-over flag.
module line_clear_ctrl #(
   parameter int unsigned COLS   = 10,
   parameter int unsigned ROWS   = 22,
   parameter int unsigned CELL_W = 3,
   parameter int unsigned HIDDEN = 2
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   input  logic                   start,
   input  logic                   clear_score,
   output logic                   busy,
   output logic                   done,
   output logic [4:0]             rd_row,
   input  logic [COLS*CELL_W-1:0] rd_data,
   output logic                   wr_en,
   output logic [4:0]             wr_row,
   output logic [COLS*CELL_W-1:0] wr_data,
   output logic [2:0]             lines_cleared,
   output logic [3:0]             hundreds_digit,
   output logic [3:0]             tens_digit,
   output logic [3:0]             ones_digit,
   output logic                   game_over
);

   localparam logic [4:0] LastRow = 5'(ROWS - 1);
   localparam logic [4:0] Hidden  = 5'(HIDDEN);

   typedef enum logic [2:0] {StIdle, StRd, StEval, StFill, StScore, StDone} state_e;

   state_e     state_q, state_d;
   logic [4:0] r_q, r_d;
   logic [4:0] w_q, w_d;
   logic [4:0] n_q, n_d;
   logic [2:0] lines_q, lines_d;
   logic [3:0] hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
   logic       go_q, go_d;

   logic       row_full, row_any;
   logic [2:0] n_sat;
   logic [3:0] inc;
   logic [4:0] ones_sum, tens_sum, hund_sum;
   logic       c1, c2;
   logic [3:0] s_hund, s_tens, s_ones;

   always_comb begin
      row_full = 1'b1;
      row_any  = 1'b0;
      for (int unsigned c = 0; c < COLS; c++) begin
         if (rd_data[c*CELL_W +: CELL_W] == '0) row_full = 1'b0;
         else                                    row_any  = 1'b1;
      end
   end

   // Score increment table; more than four rows is not legal play and scores as four.
   always_comb begin
      n_sat = (n_q > 5'd4) ? 3'd4 : n_q[2:0];
      unique case (n_sat)
         3'd0:    inc = 4'd0;
         3'd1:    inc = 4'd1;
         3'd2:    inc = 4'd3;
         3'd3:    inc = 4'd5;
         default: inc = 4'd8;
      endcase
   end

   always_comb begin
      c1       = 1'b0;
      c2       = 1'b0;
      ones_sum = {1'b0, ones_q} + {1'b0, inc};
      if (ones_sum > 5'd9) begin
         ones_sum = ones_sum - 5'd10;
         c1       = 1'b1;
      end
      tens_sum = {1'b0, tens_q} + {4'b0, c1};
      if (tens_sum > 5'd9) begin
         tens_sum = tens_sum - 5'd10;
         c2       = 1'b1;
      end
      hund_sum = {1'b0, hund_q} + {4'b0, c2};
      if (hund_sum > 5'd9) begin
         s_hund = 4'd9;
         s_tens = 4'd9;
         s_ones = 4'd9;
      end else begin
         s_hund = hund_sum[3:0];
         s_tens = tens_sum[3:0];
         s_ones = ones_sum[3:0];
      end
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      w_d     = w_q;
      n_d     = n_q;
      lines_d = lines_q;
      hund_d  = hund_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      go_d    = go_q;
      wr_en   = 1'b0;
      wr_row  = '0;
      wr_data = '0;
      unique case (state_q)
         StIdle: begin
            if (clear_score) begin
               hund_d = '0;
               tens_d = '0;
               ones_d = '0;
               go_d   = 1'b0;
            end
            if (start) begin
               state_d = StRd;
               r_d     = LastRow;
               w_d     = LastRow;
               n_d     = '0;
            end
         end
         StRd: state_d = StEval;
         StEval: begin
            if (row_full) begin
               n_d = n_q + 5'd1;
            end else begin
               if (w_q != r_q) begin
                  wr_en   = 1'b1;
                  wr_row  = w_q;
                  wr_data = rd_data;
               end
               w_d = w_q - 5'd1;
               if (r_q < Hidden && row_any) go_d = 1'b1;
            end
            if (r_q == '0) begin
               state_d = (n_d != '0) ? StFill : StScore;
            end else begin
               r_d     = r_q - 5'd1;
               state_d = StRd;
            end
         end
         // After the scan w sits at n-1, so it walks the zero-fill down to row 0.
         StFill: begin
            wr_en  = 1'b1;
            wr_row = w_q;
            if (w_q == '0) state_d = StScore;
            else           w_d     = w_q - 5'd1;
         end
         StScore: begin
            lines_d = n_sat;
            hund_d  = s_hund;
            tens_d  = s_tens;
            ones_d  = s_ones;
            state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= StIdle;
         r_q     <= '0;
         w_q     <= '0;
         n_q     <= '0;
         lines_q <= '0;
         hund_q  <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         w_q     <= w_d;
         n_q     <= n_d;
         lines_q <= lines_d;
         hund_q  <= hund_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         go_q    <= go_d;
      end
   end

   assign busy           = (state_q != StIdle);
   assign done           = (state_q == StDone);
   assign rd_row         = r_q;
   assign lines_cleared  = lines_q;
   assign hundreds_digit = hund_q;
   assign tens_digit     = tens_q;
   assign ones_digit     = ones_q;
   assign game_over      = go_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl: behavioural grid store, table of clear passes,
// plus hand sequences for score saturation, ignored start and mid-pass reset.
module tb_line_clear_ctrl;

   localparam int COLS   = 10;
   localparam int ROWS   = 22;
   localparam int CELL_W = 3;
   localparam int RW     = COLS * CELL_W;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          start = 1'b0;
   logic          clear_score = 1'b0;
   logic          busy, done, wr_en, game_over;
   logic [4:0]    rd_row, wr_row;
   logic [RW-1:0] rd_data = '0;
   logic [RW-1:0] wr_data;
   logic [2:0]    lines_cleared;
   logic [3:0]    hundreds_digit, tens_digit, ones_digit;

   line_clear_ctrl dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .start         (start),
      .clear_score   (clear_score),
      .busy          (busy),
      .done          (done),
      .rd_row        (rd_row),
      .rd_data       (rd_data),
      .wr_en         (wr_en),
      .wr_row        (wr_row),
      .wr_data       (wr_data),
      .lines_cleared (lines_cleared),
      .hundreds_digit(hundreds_digit),
      .tens_digit    (tens_digit),
      .ones_digit    (ones_digit),
      .game_over     (game_over)
   );

   always #5 Clk = ~Clk;

   logic [RW-1:0] grid      [ROWS];
   logic [RW-1:0] init_grid [ROWS];
   logic [RW-1:0] exp_grid  [ROWS];
   logic          load_req = 1'b0;
   int            nwr = 0;
   int            ndone = 0;
   int            checks = 0;
   int            errors = 0;

   always @(posedge Clk) begin
      if (load_req) begin
         for (int i = 0; i < ROWS; i++) grid[i] <= init_grid[i];
      end else if (wr_en && wr_row < 5'(ROWS)) begin
         grid[wr_row] <= wr_data;
      end
      rd_data <= (rd_row < 5'(ROWS)) ? grid[rd_row] : '0;
   end

   always @(negedge Clk) begin
      if (wr_en) nwr++;
      if (done)  ndone++;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] full_row(input int r);
      logic [RW-1:0] v = '0;
      for (int c = 0; c < COLS; c++) v[c*CELL_W +: CELL_W] = 3'(((c + r) % 7) + 1);
      return v;
   endfunction

   function automatic logic [RW-1:0] part_row(input int r);
      logic [RW-1:0] v = '0;
      v[(r % COLS)*CELL_W +: CELL_W] = 3'((r % 7) + 1);
      return v;
   endfunction

   // Load the store and build the expected compacted image.
   task automatic load(input logic [21:0] full, input logic [21:0] part);
      int j;
      for (int r = 0; r < ROWS; r++) begin
         if (full[r])      init_grid[r] = full_row(r);
         else if (part[r]) init_grid[r] = part_row(r);
         else              init_grid[r] = '0;
         exp_grid[r] = '0;
      end
      j = ROWS - 1;
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (!full[r]) begin
            exp_grid[j] = init_grid[r];
            j--;
         end
      end
      @(negedge Clk);
      load_req = 1'b1;
      @(negedge Clk);
      load_req = 1'b0;
   endtask

   task automatic check_grid(input string name);
      int bad = 0;
      for (int r = 0; r < ROWS; r++) if (grid[r] !== exp_grid[r]) bad++;
      chk(name, bad, 0);
   endtask

   // cyc counts clock edges with the start edge as 1; -1 if done never came.
   task automatic run_pass(input logic clr, input int poke, output int cyc,
                           output int writes, output int dones);
      int cnt, w0, d0;
      w0 = nwr;
      d0 = ndone;
      cyc = -1;
      @(negedge Clk);
      start = 1'b1;
      clear_score = clr;
      @(posedge Clk);
      cnt = 1;
      @(negedge Clk);
      start = 1'b0;
      clear_score = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (done) begin
            cyc = cnt;
            break;
         end
         @(posedge Clk);
         cnt++;
         @(negedge Clk);
         start = (cnt == poke);
      end
      start = 1'b0;
      if (poke > 0) repeat (60) @(negedge Clk);
      writes = nwr - w0;
      dones  = ndone - d0;
   endtask

   function automatic int score();
      return int'(hundreds_digit) * 100 + int'(tens_digit) * 10 + int'(ones_digit);
   endfunction

   typedef struct {
      logic        clr;
      logic [21:0] full;
      logic [21:0] part;
      int          lines;
      int          score;
      int          go;
      int          cyc;
      int          writes;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int cyc, wr, dn, exp_s;

      vecs[0] = '{1'b1, 22'h000000, 22'h000000, 0,  0, 0, 46,  0};
      vecs[1] = '{1'b0, 22'h200000, 22'h100000, 1,  1, 0, 47, 22};
      vecs[2] = '{1'b0, 22'h280000, 22'h140000, 2,  4, 0, 48, 22};
      vecs[3] = '{1'b0, 22'h3C0000, 22'h020000, 4, 12, 0, 50, 22};
      vecs[4] = '{1'b0, 22'h000000, 22'h000002, 0, 12, 1, 46,  0};
      vecs[5] = '{1'b0, 22'h000000, 22'h000000, 0, 12, 1, 46,  0};
      vecs[6] = '{1'b1, 22'h000000, 22'h000000, 0,  0, 0, 46,  0};
      vecs[7] = '{1'b0, 22'h380000, 22'h000001, 3,  5, 1, 49, 22};
      vecs[8] = '{1'b1, 22'h000001, 22'h000000, 1,  1, 0, 47,  1};
      vecs[9] = '{1'b0, 22'h3E0000, 22'h000000, 4,  9, 0, 51, 22};

      repeat (3) @(negedge Clk);
      chk("reset_busy",  int'(busy), 0);
      chk("reset_done",  int'(done), 0);
      chk("reset_wr_en", int'(wr_en), 0);
      chk("reset_lines", int'(lines_cleared), 0);
      chk("reset_score", score(), 0);
      chk("reset_go",    int'(game_over), 0);
      Reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         load(vecs[i].full, vecs[i].part);
         run_pass(vecs[i].clr, 0, cyc, wr, dn);
         chk($sformatf("v%0d_cycle", i),  cyc, vecs[i].cyc);
         chk($sformatf("v%0d_lines", i),  int'(lines_cleared), vecs[i].lines);
         chk($sformatf("v%0d_score", i),  score(), vecs[i].score);
         chk($sformatf("v%0d_go", i),     int'(game_over), vecs[i].go);
         chk($sformatf("v%0d_writes", i), wr, vecs[i].writes);
         @(negedge Clk);
         check_grid($sformatf("v%0d_grid", i));
      end

      // Four-line passes from a cleared score until well past saturation.
      exp_s = 0;
      for (int p = 0; p < 127; p++) begin
         load(22'h3C0000, 22'h0);
         run_pass(p == 0, 0, cyc, wr, dn);
         exp_s = (exp_s + 8 > 999) ? 999 : exp_s + 8;
         chk($sformatf("sat_score_%0d", p), score(), exp_s);
      end
      chk("sat_lines", int'(lines_cleared), 4);

      // start mid-pass is ignored.
      load(22'h200000, 22'h100000);
      run_pass(1'b1, 10, cyc, wr, dn);
      chk("poke_cycle", cyc, 47);
      chk("poke_dones", dn, 1);
      chk("poke_score", score(), 1);

      // Reset in the middle of a pass.
      load(22'h200000, 22'h000002);
      run_pass(1'b0, 0, cyc, wr, dn);
      chk("prerst_go", int'(game_over), 1);
      chk("prerst_score", score(), 2);
      load(22'h200000, 22'h000002);
      @(negedge Clk);
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      repeat (18) @(negedge Clk);
      chk("rst_busy_before", int'(busy), 1);
      #1 Reset_n = 1'b0;
      #1;
      chk("rst_busy",  int'(busy), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_score", score(), 0);
      chk("rst_go",    int'(game_over), 0);
      chk("rst_done",  int'(done), 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      load(22'h200000, 22'h100000);
      run_pass(1'b0, 0, cyc, wr, dn);
      chk("postrst_cycle", cyc, 47);
      chk("postrst_lines", int'(lines_cleared), 1);
      chk("postrst_score", score(), 1);
      chk("postrst_go",    int'(game_over), 0);
      @(negedge Clk);
      check_grid("postrst_grid");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
